// File: rtl/viagem_pkg.sv
// viagem_pkg
//   Shared definitions for the trip block and its neighbours:
//   - state_t   : trip FSM encoding (IDLE=0, BOARD=1, RIDE=2, ARRIVED=3)
//   - VERDE_OK  : green-LED word meaning "driver is at the pickup point",
//                 shared with the driver-approach block
//   - onehot_ok : 1 when exactly one bit of a vector (up to 32 bits) is set
package viagem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOARD   = 2'd1,
        RIDE    = 2'd2,
        ARRIVED = 2'd3
    } state_t;

    localparam logic [7:0] VERDE_OK = 8'hFF;

    // Callers zero-extend their vector to 32 bits; position vectors are
    // never wider than that on this board.
    function automatic logic onehot_ok(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/viagem_divisor_passo.sv
// divisor_passo
//   Step-tick generator. Counts clk cycles and raises tick for one cycle
//   every STEP_DIV cycles. clr restarts the count from zero, so the first
//   tick after a clear comes STEP_DIV cycles later.
// Ports
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   clr   in  1  synchronous restart of the count
//   tick  out 1  high while the count sits at STEP_DIV-1
module divisor_passo #(
    parameter int STEP_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/viagem.sv
// viagem
//   Trip block: after the approach block reports the driver at the pickup
//   (chegou == VERDE_OK) it boards the passenger, walks a one-hot position
//   across the red LEDs toward the destination one LED per step tick,
//   accumulates steps and fare, lights the green LEDs on arrival and waits
//   for the passenger to acknowledge.
// Ports
//   clk          in  1       system clock
//   rst_n        in  1       asynchronous active-low reset
//   chegou       in  8       approach-block green word, VERDE_OK = at pickup
//   inicio       in  N_POS   one-hot pickup position
//   fim          in  N_POS   one-hot destination position
//   confirma     in  1       passenger acknowledge (level)
//   cancela      in  1       abort trip, beats everything but reset
//   fio          out N_POS   current car position (LEDR)
//   acende_verde out 8       all ones while ARRIVED
//   em_corrida   out 1       high in BOARD and RIDE
//   fim_viagem   out 1       one-cycle pulse on entry to ARRIVED
//   erro         out 1       bad pickup/destination while driver waits
//   passos       out 4       steps taken this trip (saturating)
//   tarifa       out FARE_W  accumulated fare (saturating)
//   estado       out 2       current FSM state, for observation
// Handshake: chegou and confirma are levels, sampled on every rising edge;
// there is no back-pressure, a qualifying level is acted on at that edge.
module viagem
    import viagem_pkg::*;
#(
    parameter int N_POS         = 9,
    parameter int STEP_DIV      = 25000000,
    parameter int BOARD_TICKS   = 2,
    parameter int FARE_W        = 8,
    parameter int FARE_BASE     = 5,
    parameter int FARE_PER_STEP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        chegou,
    input  logic [N_POS-1:0]  inicio,
    input  logic [N_POS-1:0]  fim,
    input  logic              confirma,
    input  logic              cancela,
    output logic [N_POS-1:0]  fio,
    output logic [7:0]        acende_verde,
    output logic              em_corrida,
    output logic              fim_viagem,
    output logic              erro,
    output logic [3:0]        passos,
    output logic [FARE_W-1:0] tarifa,
    output state_t            estado
);

    localparam int BW = (BOARD_TICKS > 1) ? $clog2(BOARD_TICKS) : 1;
    localparam logic [BW-1:0] BOARD_LAST = BW'(BOARD_TICKS - 1);

    state_t            state, state_next;
    logic [N_POS-1:0]  pos, pos_next;
    logic [N_POS-1:0]  dest, dest_next;
    logic [BW-1:0]     board_cnt, board_cnt_next;
    logic [3:0]        passos_next;
    logic [FARE_W-1:0] tarifa_next;
    logic [FARE_W:0]   tarifa_sum;
    logic              tick;
    logic              pedido_ok;
    logic              pedido_mau;
    logic              entra_estado;

    assign pedido_ok  = onehot_ok(32'(inicio)) && onehot_ok(32'(fim));
    assign pedido_mau = (chegou == VERDE_OK) && !pedido_ok;
    assign tarifa_sum = {1'b0, tarifa} + (FARE_W + 1)'(FARE_PER_STEP);

    // Restart the step divider on every state change so each state's
    // first tick lands a full STEP_DIV cycles after entry.
    assign entra_estado = (state_next != state);

    divisor_passo #(
        .STEP_DIV (STEP_DIV)
    ) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (entra_estado),
        .tick  (tick)
    );

    always_comb begin
        state_next     = state;
        pos_next       = pos;
        dest_next      = dest;
        board_cnt_next = board_cnt;
        passos_next    = passos;
        tarifa_next    = tarifa;

        if (cancela) begin
            // Abort freezes passos/tarifa; a tick this cycle is discarded.
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if ((chegou == VERDE_OK) && pedido_ok) begin
                        state_next     = BOARD;
                        pos_next       = inicio;
                        dest_next      = fim;
                        board_cnt_next = '0;
                        passos_next    = 4'd0;
                        tarifa_next    = FARE_W'(FARE_BASE);
                    end
                end
                BOARD: begin
                    if (tick) begin
                        if (board_cnt == BOARD_LAST) begin
                            state_next = (pos == dest) ? ARRIVED : RIDE;
                        end else begin
                            board_cnt_next = board_cnt + BW'(1);
                        end
                    end
                end
                RIDE: begin
                    if (tick && (pos != dest)) begin
                        // One-hot vectors compare like their bit indices.
                        if (pos > dest) begin
                            pos_next = pos >> 1;
                        end else begin
                            pos_next = pos << 1;
                        end
                        if (passos != 4'hF) begin
                            passos_next = passos + 4'd1;
                        end
                        if (tarifa_sum[FARE_W]) begin
                            tarifa_next = '1;
                        end else begin
                            tarifa_next = tarifa_sum[FARE_W-1:0];
                        end
                        if (pos_next == dest) begin
                            state_next = ARRIVED;
                        end
                    end
                end
                ARRIVED: begin
                    if (confirma) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pos       <= '0;
            dest      <= '0;
            board_cnt <= '0;
        end else begin
            state     <= state_next;
            pos       <= pos_next;
            dest      <= dest_next;
            board_cnt <= board_cnt_next;
        end
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fio          <= '0;
            acende_verde <= 8'h00;
            em_corrida   <= 1'b0;
            fim_viagem   <= 1'b0;
            erro         <= 1'b0;
            passos       <= 4'd0;
            tarifa       <= '0;
        end else begin
            fio          <= (state_next == IDLE) ? '0 : pos_next;
            acende_verde <= (state_next == ARRIVED) ? VERDE_OK : 8'h00;
            em_corrida   <= (state_next == BOARD) || (state_next == RIDE);
            fim_viagem   <= (state_next == ARRIVED) && (state != ARRIVED);
            erro         <= (state_next == IDLE) && pedido_mau;
            passos       <= passos_next;
            tarifa       <= tarifa_next;
        end
    end

    assign estado = state;

endmodule
